trgmod_v4: RTL

Dual-channel hysteresis trigger and event packer for the 14-bit ADC sample stream. It sits directly downstream of the GPIO controller and consumes its two threshold pairs `TRGLEVEL_1`/`TRGLEVEL_2` ({H[27:14], L[13:0]}) and its sleep control. For each pulse crossing it fires a trigger strobe and measures the pulse peak. It writes one 32-bit event word per pulse into the acquisition FIFO, which the controller later drains over GPIO.

---
 rtl/trgmod_v4.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/trgmod_v4.sv
// trgmod_v4: dual-channel hysteresis trigger and event packer.
// Each channel arms below its low threshold, fires when a sample reaches its
// high threshold, tracks the pulse peak, and emits {id, peak, ts_fire} when the
// sample drops back below the low threshold. A single write port feeds the FIFO;
// a one-entry pending slot defers channel 2 when both channels end together.
module trgmod_v4 (
  input  logic        sys_clk,
  input  logic        _RESET_in,
  input  logic [13:0] ADC_data,
  input  logic        ADC_valid,
  input  logic [27:0] TRGLEVEL_1_in,
  input  logic [27:0] TRGLEVEL_2_in,
  input  logic        SLEAP_in,
  input  logic        full,
  output logic        TRG1_out,
  output logic        TRG2_out,
  output logic [31:0] FIFO_data_out,
  output logic        FIFO_wr_out,
  output logic [7:0]  DROP_cnt
);

  typedef enum logic [1:0] {IDLE, ARMED, ABOVE} state_t;

  logic [15:0] ts_q;
  logic [27:0] lvl [2];
  logic [1:0]  fire;
  logic [1:0]  emit;
  logic [31:0] word [2];

  assign lvl[0] = TRGLEVEL_1_in;
  assign lvl[1] = TRGLEVEL_2_in;

  // Sample timestamp: counts every valid sample, wraps, ignores sleep.
  always_ff @(posedge sys_clk or negedge _RESET_in) begin
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent behaviour.
    if (!_RESET_in)     ts_q <= '0;
    else if (ADC_valid) ts_q <= ts_q + 16'd1;
  end

  for (genvar n = 0; n < 2; n++) begin : g_ch
    localparam logic [1:0] ID = 2'(n + 1);

    state_t      state_q, state_d;
    logic [13:0] peak_q, peak_d;
    logic [15:0] tsf_q, tsf_d;
    logic [13:0] lvl_h, lvl_l;
    logic        en;
    logic        fire_c, emit_c;

    assign lvl_h = lvl[n][27:14];
    assign lvl_l = lvl[n][13:0];
    assign en    = SLEAP_in && (lvl_h > lvl_l);

    // Channel state, peak and fire timestamp registers.
    always_ff @(posedge sys_clk or negedge _RESET_in) begin
      if (!_RESET_in) begin
        state_q <= IDLE;
        peak_q  <= '0;
        tsf_q   <= '0;
      end else begin
        state_q <= state_d;
        peak_q  <= peak_d;
        tsf_q   <= tsf_d;
      end
    end

    // Hysteresis FSM: disabled channels fall back to IDLE and need a new baseline.
    always_comb begin
      // NOTE: every output gets a default before any branch, so no path leaves
      // a signal unassigned and no latch is inferred.
      state_d = state_q;
      peak_d  = peak_q;
      tsf_d   = tsf_q;
      fire_c  = 1'b0;
      emit_c  = 1'b0;
      if (!en) begin
        state_d = IDLE;
      end else if (ADC_valid) begin
        unique case (state_q)
          IDLE:  if (ADC_data < lvl_l) state_d = ARMED;
          ARMED: if (ADC_data >= lvl_h) begin
            state_d = ABOVE;
            fire_c  = 1'b1;
            tsf_d   = ts_q;
            peak_d  = ADC_data;
          end
          ABOVE: begin
            if (ADC_data < lvl_l) begin
              state_d = ARMED;
              emit_c  = 1'b1;
            end else if (ADC_data > peak_q) begin
              peak_d = ADC_data;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    assign fire[n] = fire_c;
    assign emit[n] = emit_c;
    // Registered peak excludes the end sample that triggers the emission.
    assign word[n] = {ID, peak_q, tsf_q};
  end

  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_word_q, pend_word_d;
  logic        cand_wr;
  logic [31:0] cand_word;
  logic [1:0]  drop_inc;
  logic [8:0]  drop_sum;
  logic [7:0]  drop_d;

  // Write arbitration: channel 1 first, then the pending slot, then channel 2.
  always_comb begin
    cand_wr     = 1'b0;
    cand_word   = word[0];
    pend_vld_d  = pend_vld_q;
    pend_word_d = pend_word_q;
    drop_inc    = 2'd0;
    if (emit[0]) begin
      cand_wr   = 1'b1;
      cand_word = word[0];
      if (emit[1]) begin
        if (pend_vld_q) begin
          drop_inc = 2'd1;
        end else begin
          pend_vld_d  = 1'b1;
          pend_word_d = word[1];
        end
      end
    end else if (pend_vld_q) begin
      cand_wr    = 1'b1;
      cand_word  = pend_word_q;
      pend_vld_d = 1'b0;
      // Slot was occupied when this emission arrived.
      if (emit[1]) drop_inc = 2'd1;
    end else if (emit[1]) begin
      cand_wr   = 1'b1;
      cand_word = word[1];
    end
    if (cand_wr && full) drop_inc = drop_inc + 2'd1;
    drop_sum = {1'b0, DROP_cnt} + {7'd0, drop_inc};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Output registers and pending slot.
  always_ff @(posedge sys_clk or negedge _RESET_in) begin
    if (!_RESET_in) begin
      TRG1_out      <= 1'b0;
      TRG2_out      <= 1'b0;
      FIFO_wr_out   <= 1'b0;
      FIFO_data_out <= '0;
      DROP_cnt      <= '0;
      // NOTE: the pending slot is a single register, so it is reset like any
      // other state; only the valid bit matters, the word is cleared for tidiness.
      pend_vld_q    <= 1'b0;
      pend_word_q   <= '0;
    end else begin
      TRG1_out    <= fire[0];
      TRG2_out    <= fire[1];
      FIFO_wr_out <= cand_wr && !full;
      if (cand_wr && !full) FIFO_data_out <= cand_word;
      DROP_cnt    <= drop_d;
      pend_vld_q  <= pend_vld_d;
      pend_word_q <= pend_word_d;
    end
  end

endmodule
